// File: rtl/kv_request_parser_v2.sv
// kv_request_parser_v2: splits a KV request stream into meta, key, malloc and
// value channels, realigning the value so its first word lands in bits [63:0].
module kv_request_parser_v2 #(
  parameter int         DATA_WIDTH    = 512,
  parameter int         KEY_MAX_WORDS = 4,
  parameter int         DROP_ON_BUSY  = 0,
  parameter logic [7:0] SET_OPCODE    = 8'h01
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [95:0]                  m_meta_data,
  output logic                         m_meta_valid,
  input  logic                         m_meta_ready,
  output logic [64*KEY_MAX_WORDS-1:0]  m_key_data,
  output logic [7:0]                   m_key_len,
  output logic                         m_key_valid,
  input  logic                         m_key_ready,
  output logic [DATA_WIDTH-1:0]        m_value_data,
  output logic                         m_value_valid,
  output logic                         m_value_last,
  input  logic                         m_value_ready,
  output logic [15:0]                  m_value_length,
  output logic [15:0]                  m_malloc_data,
  output logic                         m_malloc_valid,
  input  logic                         m_malloc_ready,
  output logic [31:0]                  stat_ok_cnt,
  output logic [31:0]                  stat_drop_cnt,
  output logic [31:0]                  stat_trunc_cnt
);

  localparam int          NW    = DATA_WIDTH / 64;
  localparam int          KW    = 64 * KEY_MAX_WORDS;
  localparam logic [15:0] NW16  = 16'(NW);
  localparam logic [7:0]  KMAX8 = 8'(KEY_MAX_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VALUE = 3'd1,
    ST_FLUSH = 3'd2,
    ST_TAIL  = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [95:0]           r_meta_data;
  logic                  r_meta_valid;
  logic [KW-1:0]         r_key_data;
  logic [7:0]            r_key_len;
  logic                  r_key_valid;
  logic [DATA_WIDTH-1:0] r_value_data;
  logic                  r_value_valid;
  logic                  r_value_last;
  logic [15:0]           r_value_length;
  logic [15:0]           r_malloc_data;
  logic                  r_malloc_valid;
  logic [31:0]           r_ok_cnt;
  logic [31:0]           r_drop_cnt;
  logic [31:0]           r_trunc_cnt;
  logic [DATA_WIDTH-1:0] r_carry;
  logic [15:0]           r_off;
  logic [15:0]           r_n0;
  logic [15:0]           r_words_left;

  logic [63:0]           w_net_meta;
  logic [7:0]            w_opcode;
  logic [7:0]            w_keylen;
  logic [15:0]           w_totlen;
  logic [15:0]           w_magic;
  logic [15:0]           w_vallen;
  logic [15:0]           w_off;
  logic [15:0]           w_n0;
  logic                  w_malformed;
  logic                  w_busy;
  logic [KW-1:0]         w_key;
  logic [DATA_WIDTH-1:0] w_beat0_carry;
  logic [DATA_WIDTH-1:0] w_comb;
  logic [DATA_WIDTH-1:0] w_next_carry;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_val_take;
  logic                  w_flush_fire;
  logic                  w_ok_inc;
  logic                  w_unused_tkeep;

  function automatic logic [DATA_WIDTH-1:0] word_mask(input logic [15:0] n);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NW; i++) begin
      if (16'(i) < n) m[64*i +: 64] = {64{1'b1}};
      else            m[64*i +: 64] = 64'd0;
    end
    return m;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    if (c == 32'hFFFF_FFFF) return c;
    else                    return c + 32'd1;
  endfunction

  assign w_unused_tkeep = ^s_axis_tkeep;

  assign w_net_meta  = s_axis_tdata[127:64];
  assign w_opcode    = s_axis_tdata[63:56];
  assign w_keylen    = s_axis_tdata[55:48];
  assign w_totlen    = s_axis_tdata[47:32];
  assign w_magic     = s_axis_tdata[15:0];
  assign w_vallen    = w_totlen - {8'h00, w_keylen};
  assign w_malformed = (w_magic != 16'hFFFF) || (w_keylen == 8'h00) ||
                       (w_keylen > KMAX8) || (w_totlen < {8'h00, w_keylen});
  // Value starts after two header words plus the key; n0 value words remain in beat 0.
  assign w_off       = 16'd2 + {8'h00, w_keylen};
  assign w_n0        = NW16 - w_off;
  assign w_busy      = r_meta_valid | r_key_valid | r_malloc_valid | r_value_valid;

  assign w_beat0_carry = s_axis_tdata >> {w_off, 6'b000000};
  assign w_comb        = r_carry | (s_axis_tdata << {r_n0, 6'b000000});
  assign w_next_carry  = s_axis_tdata >> {r_off, 6'b000000};
  assign w_ok_inc      = (w_accept && (w_vallen == 16'd0)) ||
                         (r_value_valid && m_value_ready && r_value_last);

  // Key extraction: only the first keylen words are kept.
  always_comb begin
    w_key = '0;
    for (int i = 0; i < KEY_MAX_WORDS; i++) begin
      if (8'(i) < w_keylen) w_key[64*i +: 64] = s_axis_tdata[128 + 64*i +: 64];
      else                  w_key[64*i +: 64] = 64'd0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and stream handshake decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_tready     = 1'b0;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_val_take   = 1'b0;
    w_flush_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!s_axis_tvalid) begin
          w_state_nxt = ST_IDLE;
        end else if (w_malformed || (w_busy && (DROP_ON_BUSY != 0))) begin
          w_tready    = 1'b1;
          w_drop      = 1'b1;
          w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DROP;
        end else if (!w_busy) begin
          w_tready = 1'b1;
          w_accept = 1'b1;
          if (w_vallen <= w_n0)  w_state_nxt = s_axis_tlast ? ST_IDLE : ST_TAIL;
          else if (s_axis_tlast) w_state_nxt = ST_FLUSH;
          else                   w_state_nxt = ST_VALUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_VALUE: begin
        w_tready = !r_value_valid || m_value_ready;
        if (s_axis_tvalid && w_tready) begin
          w_val_take = 1'b1;
          if (r_words_left <= NW16) w_state_nxt = s_axis_tlast ? ST_IDLE : ST_TAIL;
          else if (s_axis_tlast)    w_state_nxt = ST_FLUSH;
          else                      w_state_nxt = ST_VALUE;
        end else begin
          w_state_nxt = ST_VALUE;
        end
      end
      ST_FLUSH: begin
        if (!r_value_valid || m_value_ready) begin
          w_flush_fire = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_TAIL, ST_DROP: begin
        w_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_state_nxt = ST_IDLE;
        else                               w_state_nxt = r_state;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output channels, realignment carry and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta_data    <= 96'd0;
      r_meta_valid   <= 1'b0;
      r_key_data     <= '0;
      r_key_len      <= 8'd0;
      r_key_valid    <= 1'b0;
      r_value_data   <= '0;
      r_value_valid  <= 1'b0;
      r_value_last   <= 1'b0;
      r_value_length <= 16'd0;
      r_malloc_data  <= 16'd0;
      r_malloc_valid <= 1'b0;
      r_ok_cnt       <= 32'd0;
      r_drop_cnt     <= 32'd0;
      r_trunc_cnt    <= 32'd0;
      r_carry        <= '0;
      r_off          <= 16'd0;
      r_n0           <= 16'd0;
      r_words_left   <= 16'd0;
    end else begin
      if (r_meta_valid && m_meta_ready)     r_meta_valid   <= 1'b0;
      if (r_key_valid && m_key_ready)       r_key_valid    <= 1'b0;
      if (r_malloc_valid && m_malloc_ready) r_malloc_valid <= 1'b0;
      if (r_value_valid && m_value_ready) begin
        r_value_valid <= 1'b0;
        r_value_last  <= 1'b0;
      end

      if (w_accept) begin
        r_meta_data    <= {w_opcode, w_keylen, w_vallen, w_net_meta};
        r_meta_valid   <= 1'b1;
        r_key_data     <= w_key;
        r_key_len      <= w_keylen;
        r_key_valid    <= 1'b1;
        r_value_length <= {w_vallen[12:0], 3'b000};
        if (w_opcode == SET_OPCODE) begin
          r_malloc_data  <= {w_vallen[12:0], 3'b000};
          r_malloc_valid <= 1'b1;
        end
        r_off        <= w_off;
        r_n0         <= w_n0;
        r_carry      <= w_beat0_carry;
        r_words_left <= w_vallen;
        // Whole value already inside beat 0: emit it straight away as the last beat.
        if ((w_vallen != 16'd0) && (w_vallen <= w_n0)) begin
          r_value_data  <= w_beat0_carry & word_mask(w_vallen);
          r_value_valid <= 1'b1;
          r_value_last  <= 1'b1;
          r_words_left  <= 16'd0;
        end
      end

      if (w_val_take) begin
        r_carry       <= w_next_carry;
        r_value_valid <= 1'b1;
        if (r_words_left <= NW16) begin
          r_value_data <= w_comb & word_mask(r_words_left);
          r_value_last <= 1'b1;
          r_words_left <= 16'd0;
        end else begin
          r_value_data <= w_comb;
          r_value_last <= 1'b0;
          r_words_left <= r_words_left - NW16;
        end
      end

      if (w_flush_fire) begin
        r_value_data  <= r_carry & word_mask(r_words_left);
        r_value_valid <= 1'b1;
        r_value_last  <= 1'b1;
        r_words_left  <= 16'd0;
        if (r_words_left > r_n0) r_trunc_cnt <= sat_inc(r_trunc_cnt);
      end

      if (w_ok_inc) r_ok_cnt   <= sat_inc(r_ok_cnt);
      if (w_drop)   r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign s_axis_tready  = w_tready & ~rst;
  assign m_meta_data    = r_meta_data;
  assign m_meta_valid   = r_meta_valid;
  assign m_key_data     = r_key_data;
  assign m_key_len      = r_key_len;
  assign m_key_valid    = r_key_valid;
  assign m_value_data   = r_value_data;
  assign m_value_valid  = r_value_valid;
  assign m_value_last   = r_value_last;
  assign m_value_length = r_value_length;
  assign m_malloc_data  = r_malloc_data;
  assign m_malloc_valid = r_malloc_valid;
  assign stat_ok_cnt    = r_ok_cnt;
  assign stat_drop_cnt  = r_drop_cnt;
  assign stat_trunc_cnt = r_trunc_cnt;

endmodule
